// File: rtl/rr_sel_arbiter_4.sv
// rr_sel_arbiter_4: four-requester round-robin arbiter driving the 2-bit select
// of a downstream 4-to-1 mux. One owner at a time, select frozen for the whole
// grant, priority rotates past the last owner, and a hold limit bounds every grant.
module rr_sel_arbiter_4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    // Counter wide enough to hold HOLD_MAX itself.
    localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic       win_any;
    logic [1:0] win_idx;
    logic       hold_hit;
    logic       rel;

    // Scan p, p+1, p+2, p+3 (mod 4) and return {found, index} of the first set
    // request. The loop runs from the far end so the nearest offset wins last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Arbitration winner and release decision for the current cycle.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = 2'b00;
        hold_hit = 1'b0;
        rel      = 1'b0;
        {win_any, win_idx} = rr_pick(req, ptr);
        hold_hit = (cnt == HOLD_LIM);
        rel      = done || !req[sel] || hold_hit;
    end

    // Arbiter FSM with registered outputs; everything clears asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'b00;
            sel     <= 2'b00;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        sel   <= win_idx;
                        grant <= 4'b0001 << win_idx;
                        busy  <= 1'b1;
                        cnt   <= CNT_ONE;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        // sel is left alone: the mux output is don't-care while idle.
                        grant   <= 4'b0000;
                        busy    <= 1'b0;
                        ptr     <= sel + 2'd1;
                        cnt     <= '0;
                        timeout <= hold_hit;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_sel_arbiter_4.md
# rr_sel_arbiter_4

Four-requester round-robin arbiter that drives the 2-bit `sel` input of the 4-to-1 mux stage directly downstream. Requesters share the mux's single output; the arbiter grants one at a time, holds `sel` steady for the whole grant, and rotates priority after each grant so no requester starves. A hold limit forcibly ends any grant that runs too long.

## Interface
- `HOLD_MAX`, default 15: maximum grant length in cycles, legal range 1..255. The grant is force-released on its `HOLD_MAX`-th cycle.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  [3:0]: request lines; bit i means requester i wants the mux.
- `done`  input  1: the current owner releases the grant; sampled only while `busy` = 1.
- `sel`  output  [1:0]: binary index of the granted requester; wired to the mux `sel`.
- `grant`  output  [3:0]: one-hot grant; all zeros when idle.
- `busy`  output  1: a grant is active; equals OR of `grant`.
- `timeout`  output  1: one-cycle pulse when a grant is force-released by `HOLD_MAX`.

## Operation
- **Internal state**
  - `state` ∈ {IDLE, GRANT}.
  - `ptr` [1:0]: highest-priority index for the next arbitration.
  - `cnt`: hold counter, width ceil(log2(HOLD_MAX+1)), saturating-safe.
- **IDLE**
  - If `req` = 0, stay in IDLE.
  - Otherwise pick the first set bit scanning `ptr`, `ptr`+1, … (mod 4).
  - Register the winner: `sel` = index, `grant` = one-hot, `busy` = 1, `cnt` = 1, go to GRANT.
- **GRANT**: `sel` and `grant` are frozen. The grant is released on the edge where any of these holds:
  - (a) `done` = 1;
  - (b) `req[sel]` = 0, i.e. the requester withdrew;
  - (c) `cnt` == `HOLD_MAX`, which also drives `timeout` = 1 for exactly that next cycle.
- **On release**
  - `grant` = 0, `busy` = 0, `ptr` = `sel` + 1 (wraps 3 → 0), go to IDLE.
  - `sel` keeps its last value; the mux output is don't-care while idle.
- **If no release condition holds**: `cnt` increments by 1.
- **Simultaneous conditions**: if (a), (b) and (c) coincide, one release occurs and `timeout` still pulses if (c) held.
- **Changes to non-granted `req` bits during GRANT**: no effect until the next IDLE arbitration.
- **Minimum idle time**: at least one IDLE cycle separates consecutive grants, even with back-to-back requests.
- **Reset value of every register**: `state` = IDLE, `ptr` = 0, `sel` = 2'b00, `grant` = 4'b0000, `busy` = 0, `timeout` = 0, `cnt` = 0. Outputs take these values immediately on `rst` assertion, independent of `clk`.

## Timing
- **Grant latency**: `req` sampled high at edge N in IDLE → `grant`/`sel`/`busy` valid after edge N (1 cycle).
- **Release latency**: `done` or `req` drop sampled at edge M → `busy` = 0 after edge M.
  - The next grant can appear after edge M+1 at the earliest, so the grant-to-grant period is ≥ 2 cycles.
- **Grant length**: a grant ends by the `HOLD_MAX`-th cycle of `busy` = 1.
  - Example: `HOLD_MAX` = 4 gives `busy` high for exactly 4 cycles if never released.
- **Reset mid-grant**: outputs clear asynchronously. The first arbitration after `rst` deasserts uses `ptr` = 0.
- **Output timing**: all outputs are registered; no combinational path from `req`/`done` to any output.

## Test plan
- **Reset**: `rst` = 1 with `req` = 4'b1111 → `grant` = 0, `busy` = 0, `sel` = 0. Release `rst` → the next edge gives `grant` = 4'b0001, `sel` = 0.
- **Rotation and wrap**: `req` = 4'b1111 held, `done` pulsed one cycle after each grant → `sel` sequence 0, 1, 2, 3, 0, with one idle cycle between grants.
- **Sparse rotation**: `req` = 4'b1010, `ptr` = 0 → grant 1, then 3, then 1. Requesters 0 and 2 are never granted.
- **Timeout** (`HOLD_MAX` = 4): `req` = 4'b0100 held, `done` = 0 → `busy` high 4 cycles, `timeout` pulses for 1 cycle as `busy` falls. The next grant goes to 2 again (`ptr` = 3, only requester 2 active).
- **Withdrawal and simultaneous events**: grant to 1, then drop `req[1]` on the same edge `done` = 1 and `cnt` == `HOLD_MAX` → a single release, `timeout` = 1 for one cycle, `ptr` = 2.
- **Reset mid-grant**: assert `rst` asynchronously between edges while `grant` = 4'b1000 → `grant` = 0 before the next edge. After release, `req` = 4'b1001 → granted 0 (`ptr` reset to 0).
